// File: rtl/load_store_unit.sv
// Data-side load/store bridge: turns a datapath load/store into one handshaked
// word-bus transaction, stalling the core until the bus acks or times out.
module load_store_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       ls_op,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic [WIDTH-1:0] load_data,
  output logic             stall,
  output logic             lsu_fault,
  output logic             bus_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  localparam logic [2:0] OpB  = 3'b000;
  localparam logic [2:0] OpH  = 3'b001;
  localparam logic [2:0] OpW  = 3'b010;
  localparam logic [2:0] OpBu = 3'b100;
  localparam logic [2:0] OpHu = 3'b101;

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       lane_q, lane_d;
  logic [WIDTH-1:0] ld_q, ld_d;
  logic             bus_err_q, bus_err_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             req, illegal, misaligned;
  logic [3:0]       be_new;
  logic [WIDTH-1:0] wdata_new;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [WIDTH-1:0] ext_data;

  // Access decode for the incoming request.
  always_comb begin
    req        = mem_read | mem_write;
    illegal    = 1'b0;
    misaligned = 1'b0;
    be_new     = 4'b0000;
    wdata_new  = store_data;
    case (ls_op)
      OpB, OpBu: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {(WIDTH/8){store_data[7:0]}};
      end
      OpH, OpHu: begin
        be_new     = 4'b0011 << {addr[1], 1'b0};
        wdata_new  = {(WIDTH/16){store_data[15:0]}};
        misaligned = addr[0];
      end
      OpW: begin
        be_new     = 4'b1111;
        misaligned = |addr[1:0];
      end
      default: illegal = 1'b1;
    endcase
  end

  // Lane extraction and extension of the returned word.
  always_comb begin
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (op_q)
      OpB:     ext_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      OpBu:    ext_data = {{(WIDTH-8){1'b0}}, byte_sel};
      OpH:     ext_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
      OpHu:    ext_data = {{(WIDTH-16){1'b0}}, half_sel};
      default: ext_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    op_d      = op_q;
    lane_d    = lane_q;
    ld_d      = ld_q;
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;
    stall     = 1'b0;
    lsu_fault = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (illegal || misaligned) begin
            lsu_fault = 1'b1;
          end else begin
            stall   = 1'b1;
            we_d    = mem_write;
            addr_d  = {addr[WIDTH-1:2], 2'b00};
            be_d    = be_new;
            wdata_d = wdata_new;
            op_d    = ls_op;
            lane_d  = addr[1:0];
            cnt_d   = '0;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        stall = 1'b1;
        cnt_d = cnt_q + CntW'(1);
        if (mem_ack) begin
          if (!we_q) ld_d = ext_data;
          state_d = StDone;
        end else if (TIMEOUT != 0 && cnt_q == CntW'(TIMEOUT - 1)) begin
          bus_err_d = 1'b1;
          ld_d      = '0;
          state_d   = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= 4'b0000;
      wdata_q   <= '0;
      op_q      <= 3'b000;
      lane_q    <= 2'b00;
      ld_q      <= '0;
      bus_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      lane_q    <= lane_d;
      ld_q      <= ld_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Request follows state so an asynchronous reset drops it immediately.
  assign mem_req   = (state_q == StBusy);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign load_data = ld_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes expectations from a
// byte-lane reference model, a negedge monitor pops and compares.
module tb_load_store_unit;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  ls_op = 3'b000;
  logic [31:0] addr = '0, store_data = '0;
  logic [31:0] load_data;
  logic        stall, lsu_fault, bus_err, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  load_store_unit #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .ls_op(ls_op),
    .addr(addr), .store_data(store_data), .load_data(load_data), .stall(stall),
    .lsu_fault(lsu_fault), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] ld;
    logic        err;
    int          stall_cycles;
    int          req_cycles;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  bit   fault_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_ld = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes and plain arithmetic on byte lanes.
  function automatic int size_of(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_fault(input logic [2:0] op, input logic [31:0] a);
    if (op == 3'd3 || op == 3'd6 || op == 3'd7) return 1'b1;
    return (a % size_of(op)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] a);
    int m;
    m = ((1 << size_of(op)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] sd);
    logic [31:0] w;
    int s;
    s = size_of(op);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    int bits;
    if (size_of(op) == 4) return rd;
    bits = 8 * size_of(op);
    v = (rd >> (8 * (a % 4))) & ((32'd1 << bits) - 1);
    if (!op[2] && v[bits-1]) v = v | ~((32'd1 << bits) - 1);
    return v;
  endfunction

  // Driver: one request, pushes expectations, then plays the memory side.
  task automatic txn(input bit rd, input bit wr, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] rdata, input int waits,
                     input bit noack);
    bus_t b;
    res_t r;
    bit f;
    f = is_fault(op, a);
    if (f) begin
      fault_q.push_back(1'b1);
    end else begin
      b.we = wr; b.addr = a & 32'hFFFF_FFFC; b.be = model_be(op, a);
      b.wdata = model_wdata(op, sd);
      bus_q.push_back(b);
      if (noack) begin
        model_ld = '0;
        r.err = 1'b1; r.stall_cycles = TIMEOUT + 1; r.req_cycles = TIMEOUT;
      end else begin
        if (!wr) model_ld = model_load(op, a, rdata);
        r.err = 1'b0; r.stall_cycles = waits + 2; r.req_cycles = waits + 1;
      end
      r.ld = model_ld;
      res_q.push_back(r);
    end
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; ls_op = op; addr = a; store_data = sd;
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
    if (f) return;
    if (noack) begin
      repeat (TIMEOUT + 1) @(posedge clk);
      #1;
    end else begin
      repeat (waits) begin @(posedge clk); #1; end
      mem_ack = 1'b1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
  endtask

  // Monitor
  int   stall_cnt = 0, req_cnt = 0;
  bit   prev_stall = 0, prev_req = 0;
  bus_t cur;

  always @(negedge clk) begin
    bus_t b;
    res_t r;
    bit   fq;
    if (!rst) begin
      stall_cnt = 0; req_cnt = 0; prev_stall = 0; prev_req = 0;
    end else begin
      if (mem_req) begin
        req_cnt++;
        if (!prev_req) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_mem_req", 32'(mem_req), 32'd0);
          end else begin
            b = bus_q.pop_front();
            cur = b;
            chk("mem_we", 32'(mem_we), 32'(b.we));
            chk("mem_addr", mem_addr, b.addr);
            chk("mem_be", 32'(mem_be), 32'(b.be));
            chk("mem_wdata", mem_wdata, b.wdata);
          end
        end else begin
          chk("bus_stable", {mem_we, mem_be, mem_addr[26:0]}, {cur.we, cur.be, cur.addr[26:0]});
        end
      end
      if (stall) begin
        stall_cnt++;
      end else if (prev_stall) begin
        if (res_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          r = res_q.pop_front();
          chk("load_data", load_data, r.ld);
          chk("bus_err", 32'(bus_err), 32'(r.err));
          chk("stall_cycles", 32'(stall_cnt), 32'(r.stall_cycles));
          chk("req_cycles", 32'(req_cnt), 32'(r.req_cycles));
        end
        stall_cnt = 0; req_cnt = 0;
      end else if (bus_err) begin
        chk("stray_bus_err", 32'(bus_err), 32'd0);
      end
      if (lsu_fault) begin
        if (fault_q.size() == 0) begin
          chk("unexpected_fault", 32'(lsu_fault), 32'd0);
        end else begin
          fq = fault_q.pop_front();
          chk("fault_no_stall", {31'd0, stall}, 32'd0);
          chk("fault_no_req", {31'd0, mem_req}, 32'(!fq));
        end
      end
      prev_req = mem_req; prev_stall = stall;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] legal_ops [5];
    logic [2:0] bad_ops [3];
    logic [2:0] op;
    logic [31:0] a;
    int k, s;
    bit rd, wr;
    legal_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bad_ops   = '{3'b011, 3'b110, 3'b111};

    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    txn(1, 0, 3'b010, 32'h100, 32'h0, 32'h0007_78B5, 0, 0);
    txn(1, 0, 3'b001, 32'h102, 32'h0, 32'h9BDF_C000, 1, 0);
    txn(1, 0, 3'b101, 32'h102, 32'h0, 32'h9BDF_C000, 0, 0);
    txn(0, 1, 3'b000, 32'h107, 32'h1234_5678, 32'h0, 3, 0);
    txn(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0);
    txn(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
    txn(1, 0, 3'b100, 32'h103, 32'h0, 32'h0, 0, 1);

    // Abort a load in its second BUSY cycle with an asynchronous reset.
    begin
      bus_t b;
      b.we = 1'b0; b.addr = 32'h200; b.be = 4'b1111; b.wdata = 32'h0;
      bus_q.push_back(b);
      @(posedge clk); #1;
      mem_read = 1'b1; ls_op = 3'b010; addr = 32'h200;
      @(posedge clk); #1;
      mem_read = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("async_rst_mem_req", 32'(mem_req), 32'd0);
      chk("async_rst_stall", 32'(stall), 32'd0);
      chk("async_rst_load_data", load_data, 32'd0);
      model_ld = '0;
      @(posedge clk); #1 rst = 1'b1;
    end
    txn(1, 0, 3'b010, 32'h204, 32'h0, 32'hCAFE_F00D, 2, 0);

    for (int n = 0; n < 150; n++) begin
      k = $urandom % 10;
      if (k == 0) op = bad_ops[$urandom % 3];
      else op = legal_ops[$urandom % 5];
      a = $urandom;
      s = size_of(op);
      if ($urandom % 4 != 0) a = a & ~(32'(s) - 32'd1);
      k = $urandom % 4;
      rd = (k != 2);
      wr = (k >= 2);
      txn(rd, wr, op, a, $urandom, $urandom, $urandom % TIMEOUT, ($urandom % 8) == 0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("res_q_drained", 32'(res_q.size()), 32'd0);
    chk("fault_q_drained", 32'(fault_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
